// File: rtl/grayscale_to_rgb_pseudocolor.sv
// grayscale_to_rgb_pseudocolor
//   Maps an 8-bit grayscale pixel to an RGB triple for display/debug.
//   mode=0 replicates gray onto R=G=B; mode=1 applies a 4-segment "jet" ramp.
//   Two-stage valid/ready pipeline, bubble-collapsing, with an end-of-line
//   sideband flag travelling alongside each pixel.
// Ports
//   clk, rst_n            rising-edge clock, async active-low reset
//   mode                  colour mode, captured with each accepted pixel
//   gray_in, eol_in       pixel and end-of-line flag
//   in_valid / in_ready   input handshake
//   R_out, G_out, B_out   OUT_W-bit channels (8-bit result replicated MSB-first)
//   eol_out               end-of-line flag of the current output pixel
//   out_valid / out_ready output handshake
module grayscale_to_rgb_pseudocolor #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [7:0]       gray_in,
  input  logic             eol_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] R_out,
  output logic [OUT_W-1:0] G_out,
  output logic [OUT_W-1:0] B_out,
  output logic             eol_out,
  output logic             out_valid,
  input  logic             out_ready
);

  // Stage 1 state
  logic       s1_valid_q;
  logic [7:0] gray_q;
  logic       eol1_q;
  logic       mode1_q;

  // Stage 2 state
  logic       s2_valid_q;
  logic [7:0] r_q, g_q, b_q;
  logic       eol2_q;

  logic       s1_load, s2_load;

  // An empty stage always loads, so bubbles collapse regardless of out_ready.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      gray_q     <= 8'd0;
      eol1_q     <= 1'b0;
      mode1_q    <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      gray_q     <= gray_in;
      eol1_q     <= eol_in;
      mode1_q    <= mode;
    end
  end

  // Jet ramp: top two bits pick the segment, low six bits stretched to 0..255
  // by repeating their MSBs into the two vacated LSBs.
  logic [1:0] seg;
  logic [5:0] f;
  logic [7:0] ramp;
  logic [7:0] r_d, g_d, b_d;

  assign seg  = gray_q[7:6];
  assign f    = gray_q[5:0];
  assign ramp = {f, f[5:4]};

  always_comb begin
    r_d = gray_q;
    g_d = gray_q;
    b_d = gray_q;
    if (mode1_q) begin
      unique case (seg)
        2'd0: begin r_d = 8'd0;        g_d = ramp;          b_d = 8'd255; end
        2'd1: begin r_d = 8'd0;        g_d = 8'd255;        b_d = 8'd255 - ramp; end
        2'd2: begin r_d = ramp;        g_d = 8'd255;        b_d = 8'd0; end
        default: begin r_d = 8'd255;   g_d = 8'd255 - ramp; b_d = 8'd0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      r_q        <= 8'd0;
      g_q        <= 8'd0;
      b_q        <= 8'd0;
      eol2_q     <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      eol2_q     <= eol1_q;
    end
  end

  // Widen by replicating the byte and keeping the top OUT_W bits.
  logic [15:0] r_rep, g_rep, b_rep;
  assign r_rep = {r_q, r_q};
  assign g_rep = {g_q, g_q};
  assign b_rep = {b_q, b_q};

  assign R_out     = r_rep[15 -: OUT_W];
  assign G_out     = g_rep[15 -: OUT_W];
  assign B_out     = b_rep[15 -: OUT_W];
  assign eol_out   = eol2_q;
  assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_grayscale_to_rgb_pseudocolor.sv
module tb_grayscale_to_rgb_pseudocolor;
  localparam int OW = 12;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          mode = 1'b0, eol_in = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0]    gray_in = 8'd0;
  logic          in_ready, eol_out, out_valid;
  logic [OW-1:0] R_out, G_out, B_out;

  grayscale_to_rgb_pseudocolor #(.OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .gray_in(gray_in), .eol_in(eol_in),
    .in_valid(in_valid), .in_ready(in_ready), .R_out(R_out), .G_out(G_out),
    .B_out(B_out), .eol_out(eol_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Replicate a byte to OW bits, MSB-first.
  function automatic logic [OW-1:0] rep(input logic [7:0] v);
    int t;
    t = v * 257;
    return OW'(t >> (16 - OW));
  endfunction

  // Reference colour map from the segment/ramp rules, in plain integers.
  typedef struct { int r; int g; int b; logic e; } exp_t;
  function automatic exp_t model(input logic [7:0] y, input logic m, input logic e);
    exp_t x;
    int s, f, rp;
    s  = y / 64;
    f  = y % 64;
    rp = f * 4 + f / 16;
    x.e = e;
    if (!m) begin x.r = y; x.g = y; x.b = y; end
    else if (s == 0) begin x.r = 0;   x.g = rp;       x.b = 255; end
    else if (s == 1) begin x.r = 0;   x.g = 255;      x.b = 255 - rp; end
    else if (s == 2) begin x.r = rp;  x.g = 255;      x.b = 0; end
    else             begin x.r = 255; x.g = 255 - rp; x.b = 0; end
    return x;
  endfunction

  typedef struct { logic [OW-1:0] r; logic [OW-1:0] g; logic [OW-1:0] b; logic e; int cyc; } px_t;
  exp_t exp_q[$];
  px_t  log_q[$];
  int   cyc = 0;
  logic have_prev = 1'b0, saw_block = 1'b0;
  logic [OW-1:0] pr, pg, pb;
  logic pe;

  // Compare process: everything sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      // Pipe holds two pixels at most; only a full pipe under stall refuses input.
      chk("in_ready", in_ready, !(exp_q.size() >= 2 && !out_ready));
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious out_valid", out_valid, 1'b0);
        end else begin
          chk("R_out", R_out, rep(8'(exp_q[0].r)));
          chk("G_out", G_out, rep(8'(exp_q[0].g)));
          chk("B_out", B_out, rep(8'(exp_q[0].b)));
          chk("eol_out", eol_out, exp_q[0].e);
        end
        if (have_prev) begin
          chk("stall hold", {R_out, G_out, B_out, eol_out}, {pr, pg, pb, pe});
        end
      end
      have_prev = out_valid && !out_ready;
      pr = R_out; pg = G_out; pb = B_out; pe = eol_out;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        log_q.push_back('{R_out, G_out, B_out, eol_out, cyc});
      end
      if (in_valid && in_ready) exp_q.push_back(model(gray_in, mode, eol_in));
    end
  end

  task automatic send(input logic [7:0] g, input logic m, input logic e);
    int n;
    logic acc;
    gray_in = g; mode = m; eol_in = e; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] sweep [6];

  initial begin
    // Reset state
    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst RGB", {R_out, G_out, B_out}, 0);
    chk("rst eol", eol_out, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // T1: gray replicate, latency 2
    log_q.delete();
    send(8'h5A, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); chk("T1 not yet", out_valid, 0);
    @(negedge clk); chk("T1 valid", out_valid, 1);
    chk("T1 R", R_out, 12'h5A5);
    chk("T1 G", G_out, 12'h5A5);
    chk("T1 B", B_out, 12'h5A5);
    @(posedge clk); #1;
    idle(3);

    // T2: jet sweep, back to back
    sweep = '{8'h00, 8'h20, 8'h40, 8'h7F, 8'hC0, 8'hFF};
    log_q.delete();
    foreach (sweep[i]) send(sweep[i], 1'b1, 1'b0);
    idle(4);
    chk("T2 count", log_q.size(), 6);
    if (log_q.size() == 6) begin
      chk("T2 p0", {log_q[0].r, log_q[0].g, log_q[0].b}, {12'h000, 12'h000, 12'hFFF});
      chk("T2 p1", {log_q[1].r, log_q[1].g, log_q[1].b}, {12'h000, 12'h828, 12'hFFF});
      chk("T2 p2", {log_q[2].r, log_q[2].g, log_q[2].b}, {12'h000, 12'hFFF, 12'hFFF});
      chk("T2 p3", {log_q[3].r, log_q[3].g, log_q[3].b}, {12'h000, 12'hFFF, 12'h000});
      chk("T2 p4", {log_q[4].r, log_q[4].g, log_q[4].b}, {12'hFFF, 12'hFFF, 12'h000});
      chk("T2 p5", {log_q[5].r, log_q[5].g, log_q[5].b}, {12'hFFF, 12'h000, 12'h000});
      for (int i = 1; i < 6; i++) chk("T2 rate", log_q[i].cyc - log_q[0].cyc, i);
    end

    // T3: stream 10 with a 4-cycle downstream stall
    log_q.delete();
    saw_block = 1'b0;
    fork
      for (int i = 0; i < 10; i++) send(8'(i * 25 + 3), 1'(i % 2), 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(5);
    chk("T3 count", log_q.size(), 10);
    chk("T3 backpressure", saw_block, 1);

    // T4: eol on the 4th of 8 pixels
    log_q.delete();
    for (int i = 0; i < 8; i++) send(8'(i * 31), 1'b1, 1'(i == 3));
    idle(4);
    chk("T4 count", log_q.size(), 8);
    if (log_q.size() == 8)
      for (int i = 0; i < 8; i++) chk("T4 eol", log_q[i].e, 1'(i == 3));

    // T5: mode toggle between consecutive pixels (seg2, f=0 -> ramp 0)
    log_q.delete();
    send(8'h80, 1'b0, 1'b0);
    send(8'h80, 1'b1, 1'b0);
    idle(4);
    chk("T5 count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("T5 gray", {log_q[0].r, log_q[0].g, log_q[0].b}, {12'h808, 12'h808, 12'h808});
      chk("T5 jet", {log_q[1].r, log_q[1].g, log_q[1].b}, {12'h000, 12'hFFF, 12'h000});
    end

    // T6: reset with two pixels in flight
    log_q.delete();
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("T6 out_valid", out_valid, 0);
    chk("T6 RGB", {R_out, G_out, B_out}, 0);
    chk("T6 eol", eol_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("T6 in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(8'h33, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); chk("T6 not yet", out_valid, 0);
    @(negedge clk); chk("T6 valid", out_valid, 1);
    chk("T6 R", R_out, 12'h333);
    @(posedge clk); #1;
    idle(4);
    chk("T6 count", log_q.size(), 1);
    if (log_q.size() == 1) chk("T6 only new", log_q[0].r, 12'h333);

    chk("drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
